// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin merge of NUM AXI-stream sources onto one channel.
// A grant is held from the first beat through tlast; each packet pays one IDLE bubble.

module axis_rr_lane #(
    parameter int DSIZE = 8,
    parameter int KSIZE = 1
) (
    input  logic             sel,
    input  logic [DSIZE-1:0] tdata,
    input  logic [KSIZE-1:0] tkeep,
    input  logic             tvalid,
    input  logic             tlast,
    input  logic             m_tready,
    output logic             tready,
    output logic [DSIZE-1:0] data,
    output logic [KSIZE-1:0] keep,
    output logic             valid,
    output logic             last
);
    // Non-selected lanes contribute zero so the top can OR-merge all lanes.
    assign tready = sel & m_tready;
    assign data   = sel ? tdata : '0;
    assign keep   = sel ? tkeep : '0;
    assign valid  = sel & tvalid;
    assign last   = sel & tlast;
endmodule

module axis_packet_rr_arbiter #(
    parameter int NUM   = 2,
    parameter int DSIZE = 8,
    parameter int KSIZE = 1,
    parameter int IDW   = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM*DSIZE-1:0] s_tdata,
    input  logic [NUM*KSIZE-1:0] s_tkeep,
    input  logic [NUM-1:0]       s_tvalid,
    input  logic [NUM-1:0]       s_tlast,
    output logic [NUM-1:0]       s_tready,
    output logic [DSIZE-1:0]     m_tdata,
    output logic [KSIZE-1:0]     m_tkeep,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic [IDW-1:0]       m_tuser,
    input  logic                 m_tready,
    output logic [15:0]          m_tcnt,
    output logic                 busy
);
    localparam int IW = IDW + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] gnt, gnt_nxt, ptr, ptr_nxt, pick;
    logic [15:0]    cnt_nxt;
    logic           found;
    logic           lock;

    logic [NUM-1:0]            sel;
    logic [NUM-1:0][DSIZE-1:0] lane_data;
    logic [NUM-1:0][KSIZE-1:0] lane_keep;
    logic [NUM-1:0]            lane_valid;
    logic [NUM-1:0]            lane_last;

    // Reset gates the datapath so an abandoned packet takes no handshake on the reset edge.
    assign lock = (state == LOCK) && aresetn;

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        assign sel[i] = lock && (gnt == IDW'(i));

        axis_rr_lane #(.DSIZE(DSIZE), .KSIZE(KSIZE)) u_lane (
            .sel      (sel[i]),
            .tdata    (s_tdata[i*DSIZE +: DSIZE]),
            .tkeep    (s_tkeep[i*KSIZE +: KSIZE]),
            .tvalid   (s_tvalid[i]),
            .tlast    (s_tlast[i]),
            .m_tready (m_tready),
            .tready   (s_tready[i]),
            .data     (lane_data[i]),
            .keep     (lane_keep[i]),
            .valid    (lane_valid[i]),
            .last     (lane_last[i])
        );
    end

    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        for (int i = 0; i < NUM; i++) begin
            m_tdata = m_tdata | lane_data[i];
            m_tkeep = m_tkeep | lane_keep[i];
        end
    end

    assign m_tvalid = |lane_valid;
    assign m_tlast  = |lane_last;
    assign m_tuser  = gnt;
    assign busy     = (state == LOCK);

    // First valid requester scanning upward from ptr, modulo NUM.
    always_comb begin
        logic [IW-1:0] idx;
        logic          v;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        v     = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            idx = {1'b0, ptr} + IW'(k);
            if (idx >= IW'(NUM))
                idx = idx - IW'(NUM);
            v = 1'b0;
            for (int j = 0; j < NUM; j++)
                if (idx == IW'(j))
                    v = s_tvalid[j];
            if (!found && v) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = m_tcnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (m_tvalid && m_tready) begin
                    if (m_tlast) begin
                        cnt_nxt   = '0;
                        ptr_nxt   = (gnt == IDW'(NUM - 1)) ? '0 : gnt + 1'b1;
                        state_nxt = IDLE;
                    end else if (m_tcnt != 16'hFFFF) begin
                        cnt_nxt = m_tcnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            m_tcnt <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            ptr    <= ptr_nxt;
            m_tcnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench: NUM=2 instance for reset/fairness/stall/backpressure/mid-reset,
// NUM=4 instance for pointer wrap and skip.
module tb_axis_packet_rr_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic [15:0] s_tdata2;
    logic [1:0]  s_tkeep2, s_tvalid2, s_tlast2, s_tready2;
    logic [7:0]  m_tdata2;
    logic [0:0]  m_tkeep2;
    logic        m_tvalid2, m_tlast2, m_tready2, busy2;
    logic [3:0]  m_tuser2;
    logic [15:0] m_tcnt2;

    logic        rst4;
    logic [31:0] s_tdata4;
    logic [3:0]  s_tkeep4, s_tvalid4, s_tlast4, s_tready4;
    logic [7:0]  m_tdata4;
    logic [0:0]  m_tkeep4;
    logic        m_tvalid4, m_tlast4, m_tready4, busy4;
    logic [3:0]  m_tuser4;
    logic [15:0] m_tcnt4;

    axis_packet_rr_arbiter #(.NUM(2), .DSIZE(8), .KSIZE(1), .IDW(4)) dut2 (
        .aclk(clk), .aresetn(aresetn),
        .s_tdata(s_tdata2), .s_tkeep(s_tkeep2), .s_tvalid(s_tvalid2), .s_tlast(s_tlast2),
        .s_tready(s_tready2),
        .m_tdata(m_tdata2), .m_tkeep(m_tkeep2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2),
        .m_tuser(m_tuser2), .m_tready(m_tready2), .m_tcnt(m_tcnt2), .busy(busy2)
    );

    axis_packet_rr_arbiter #(.NUM(4), .DSIZE(8), .KSIZE(1), .IDW(4)) dut4 (
        .aclk(clk), .aresetn(rst4),
        .s_tdata(s_tdata4), .s_tkeep(s_tkeep4), .s_tvalid(s_tvalid4), .s_tlast(s_tlast4),
        .s_tready(s_tready4),
        .m_tdata(m_tdata4), .m_tkeep(m_tkeep4), .m_tvalid(m_tvalid4), .m_tlast(m_tlast4),
        .m_tuser(m_tuser4), .m_tready(m_tready4), .m_tcnt(m_tcnt4), .busy(busy4)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Source model for dut2: per-requester beat counter, fixed packet length.
    logic [1:0] v;
    logic       mr;
    int         len [2];
    int         bc  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            s_tdata2[i*8 +: 8] = {4'(i), 4'(bc[i])};
            s_tlast2[i]        = (bc[i] == len[i] - 1);
        end
        s_tkeep2  = 2'b11;
        s_tvalid2 = v;
        m_tready2 = mr;
    endtask

    task automatic cyc();
        logic [1:0] hs;
        hs = s_tvalid2 & s_tready2;
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (hs[i] === 1'b1)
                bc[i] = s_tlast2[i] ? 0 : bc[i] + 1;
        #1;
        drive();
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        rst4    = 1'b0;
        v       = 2'b11;
        mr      = 1'b1;
        len[0]  = 4; len[1] = 4;
        bc[0]   = 0; bc[1]  = 0;
        drive();
        s_tdata4  = 32'h33221100;
        s_tkeep4  = 4'hF;
        s_tlast4  = 4'hF;
        s_tvalid4 = 4'b1000;
        m_tready4 = 1'b1;

        repeat (3) begin
            cyc();
            chk("rst_tready", 32'(s_tready2), 0);
            chk("rst_tvalid", 32'(m_tvalid2), 0);
            chk("rst_busy",   32'(busy2), 0);
            chk("rst_tcnt",   32'(m_tcnt2), 0);
        end

        // Fairness: four 4-beat packets alternate 0,1,0,1 with one bubble between.
        aresetn = 1'b1;
        cyc();
        for (int p = 0; p < 4; p++) begin
            if (p > 0) begin
                chk("bubble_busy",   32'(busy2), 0);
                chk("bubble_tvalid", 32'(m_tvalid2), 0);
                cyc();
            end
            for (int j = 0; j < 4; j++) begin
                chk("fair_user",   32'(m_tuser2), 32'(p % 2));
                chk("fair_tcnt",   32'(m_tcnt2), 32'(j));
                chk("fair_data",   32'(m_tdata2), 32'({4'(p % 2), 4'(j)}));
                chk("fair_last",   32'(m_tlast2), 32'(j == 3));
                chk("fair_tready", 32'(s_tready2), 32'(1) << (p % 2));
                cyc();
            end
        end

        // Requester 0 stalls mid-packet; requester 1 must wait.
        len[0] = 3; len[1] = 2;
        drive(); #1;
        chk("stall_idle", 32'(busy2), 0);
        cyc();
        chk("stall_user0", 32'(m_tuser2), 0);
        chk("stall_b0",    32'(m_tcnt2), 0);
        cyc();
        chk("stall_b1",    32'(m_tcnt2), 1);
        cyc();
        v = 2'b10; drive(); #1;
        repeat (2) begin
            chk("stall_tvalid", 32'(m_tvalid2), 0);
            chk("stall_busy",   32'(busy2), 1);
            chk("stall_user",   32'(m_tuser2), 0);
            cyc();
        end
        v = 2'b11; drive(); #1;
        chk("stall_b2_tcnt", 32'(m_tcnt2), 2);
        chk("stall_b2_last", 32'(m_tlast2), 1);
        chk("stall_b2_data", 32'(m_tdata2), 32'h02);
        cyc();
        chk("stall_bubble", 32'(busy2), 0);
        cyc();
        chk("stall_next_user", 32'(m_tuser2), 1);
        chk("stall_next_tcnt", 32'(m_tcnt2), 0);
        cyc();
        cyc();

        // Backpressure: beat held until accepted, counter advances only on handshakes.
        len[0] = 4; v = 2'b01; drive(); #1;
        chk("bp_idle", 32'(busy2), 0);
        cyc();
        for (int c = 0; c < 8; c++) begin
            mr = (c % 2 == 1); drive(); #1;
            chk("bp_data",   32'(m_tdata2), 32'(c / 2));
            chk("bp_tcnt",   32'(m_tcnt2), 32'(c / 2));
            chk("bp_last",   32'(m_tlast2), 32'(c / 2 == 3));
            chk("bp_tvalid", 32'(m_tvalid2), 1);
            chk("bp_tready", 32'(s_tready2), 32'(mr));
            cyc();
        end
        chk("bp_done_busy", 32'(busy2), 0);
        chk("bp_done_tcnt", 32'(m_tcnt2), 0);

        // Mid-packet reset on beat 2 of requester 1's packet.
        mr = 1'b1; v = 2'b11; len[1] = 4; drive(); #1;
        cyc();
        chk("mrst_user", 32'(m_tuser2), 1);
        cyc();
        cyc();
        chk("mrst_b2_tcnt", 32'(m_tcnt2), 2);
        aresetn = 1'b0; #1;
        chk("mrst_tready_gated", 32'(s_tready2), 0);
        cyc();
        chk("mrst_busy",   32'(busy2), 0);
        chk("mrst_tcnt",   32'(m_tcnt2), 0);
        chk("mrst_tvalid", 32'(m_tvalid2), 0);
        aresetn = 1'b1;
        cyc();
        chk("mrst_after_user", 32'(m_tuser2), 0);
        chk("mrst_after_tcnt", 32'(m_tcnt2), 0);
        chk("mrst_after_busy", 32'(busy2), 1);

        // NUM=4: grant 3, then only requester 1 valid -> wrap and skip, next ptr 2.
        rst4 = 1'b1;
        @(posedge clk); #2;
        chk("w4_user3", 32'(m_tuser4), 3);
        chk("w4_data3", 32'(m_tdata4), 32'h33);
        chk("w4_busy",  32'(busy4), 1);
        chk("w4_last",  32'(m_tlast4), 1);
        @(posedge clk); #1;
        s_tvalid4 = 4'b0010; #1;
        chk("w4_bubble", 32'(busy4), 0);
        @(posedge clk); #2;
        chk("w4_user1", 32'(m_tuser4), 1);
        chk("w4_data1", 32'(m_tdata4), 32'h11);
        @(posedge clk); #1;
        s_tvalid4 = 4'b1111; #1;
        chk("w4_bubble2", 32'(busy4), 0);
        @(posedge clk); #2;
        chk("w4_user2", 32'(m_tuser4), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
